shiftreg_chain_ctrl: RTL
========================

Name: shiftreg_chain_ctrl

Overview:
Sequencer for a linear chain of DEPTH int8 shift-register stages. Each stage has `load`, `pload[7:0]`, `shin[7:0]` and `out[7:0]`. With load=0 the stage captures shin every cycle; with load=1 it captures pload.
- The block accepts a parallel int8 vector via valid/ready.
- It parallel-loads the vector into the chain, then counts DEPTH shift cycles.
- It tags the serial stream emerging from the head stage (stage 0) with valid/last.
- It feeds the tail stage's shin.
- It sits between the vector producer (e.g. weight/activation buffer) and the per-row systolic feed.

Parameters:
- DEPTH, 4, number of int8 stages in the chain (>=2).
- CW, $clog2(DEPTH)+1, internal shift-counter width (derived; do not override).

Ports:
- clk, input, 1, clock; all state updates on posedge.
- reset, input, 1, synchronous, active-low reset (reset=0 clears state on next posedge).
- vec_valid, input, 1, producer has a vector on vec_data.
- vec_ready, output, 1, block will accept vec_data this cycle.
- vec_data, input, DEPTH*8, element k in bits [8k+7:8k]; element 0 emerges first.
- sr_load, output, 1, broadcast to every stage's load.
- sr_pload, output, DEPTH*8, slice k goes to stage k pload.
- sr_fill, output, 8, drives the tail stage (DEPTH-1) shin. Stage k shin = stage k+1 out externally.
- sr_head, input, 8, stage 0 out.
- out_valid, output, 1, out_data is a valid stream element.
- out_data, output, 8, equals sr_head.
- out_last, output, 1, final element of the current pass.
- busy, output, 1, state != IDLE.

Behaviour:
- States: IDLE, SHIFT. Counter cnt[CW-1:0].
- Reset (reset=0 at posedge): state=IDLE, cnt=0. Outputs after reset: vec_ready=1, sr_load=0, out_valid=0, out_last=0, busy=0, sr_fill=0. Chain contents are don't-care.
- Reset mid-SHIFT: remaining elements are abandoned, and out_valid is 0 from the next cycle.
- Accept: vec_ready=1 in IDLE, or in SHIFT when cnt==DEPTH-1 and no repeat is pending. Handshake = vec_valid & vec_ready.
- sr_load = handshake, combinational. sr_pload = vec_data, combinational pass-through. Stages capture on the same edge.
- On handshake: state->SHIFT, cnt->0.
- SHIFT, element timing:
  - out_valid=1.
  - The element at out_data in cycle cnt=i is vector element i. Latency is 1 cycle from handshake to element 0.
  - out_last=1 when cnt==DEPTH-1.
- SHIFT, advance:
  - cnt<DEPTH-1: cnt++.
  - cnt==DEPTH-1 with handshake: cnt->0 and stay in SHIFT. This gives zero-bubble back-to-back streaming.
  - cnt==DEPTH-1 without handshake: ->IDLE.
- No output backpressure: stages always shift, so the consumer must accept every out_valid beat.
- sr_fill = 8'h00 (zero fill) unless the optional feature is enabled.
- vec_valid while busy and not at the accept point: ignored (vec_ready=0). The producer must hold the vector.
- vec_valid is don't-care when vec_ready=0. sr_load is never asserted outside a handshake.

Optional Feature:
- Macro: SRCTRL_REPEAT_EN.
- Defined:
  - Adds input port cfg_repeat[3:0], sampled at handshake into rep_left.
  - sr_fill = sr_head (combinational), so the chain rotates.
  - At cnt==DEPTH-1: if rep_left!=0, then rep_left--, cnt->0, stay in SHIFT with vec_ready=0. The same vector is streamed again.
  - Total passes = cfg_repeat+1. out_last marks the final element of each pass.
  - Handshake is only possible at cnt==DEPTH-1 with rep_left==0.
- Undefined: no cfg_repeat port, sr_fill=0, single pass per vector.

Test Plan (DEPTH=4, chain modelled with 4 int8 stages):
1. Reset/idle:
   - Hold reset=0 for 2 cycles, then release.
   - Required: vec_ready=1, busy=0, out_valid=0, sr_load=0, sr_fill=0.
2. Single vector:
   - vec_data=32'h44332211, vec_valid 1 cycle.
   - Required: sr_load=1 that cycle. Next 4 cycles out_data=11,22,33,44 with out_valid=1 and out_last only on 44. Then IDLE.
3. Back-to-back:
   - Present vector B=32'hDDCCBBAA at the cycle out_last of A.
   - Required: handshake that cycle, followed by an uninterrupted 8-beat stream 11,22,33,44,AA,BB,CC,DD.
4. Busy hold:
   - Assert vec_valid continuously from the cycle after accepting A.
   - Required: vec_ready=0 for cnt=0..2. Next acceptance occurs at cnt=3. No stray sr_load.
5. Reset mid-shift:
   - Drive reset=0 when cnt==1.
   - Required: out_valid=0 and busy=0 from the next cycle, and vec_ready=1 after release.
6. SRCTRL_REPEAT_EN:
   - cfg_repeat=2, vector 32'h04030201.
   - Required: 12 beats 01,02,03,04 ×3, with out_last on each 04 and vec_ready=0 until the third 04.

Source files
------------

// File: rtl/shiftreg_chain_ctrl_if.sv
// Vector-in / stream-out bundle for shiftreg_chain_ctrl.
// The master side is the producer/consumer environment; the slave side is the sequencer.
interface shiftreg_chain_ctrl_if #(
  parameter int DEPTH = 4
);
  logic               vec_valid;
  logic               vec_ready;
  logic [DEPTH*8-1:0] vec_data;
  logic               out_valid;
  logic [7:0]         out_data;
  logic               out_last;

  modport master (
    output vec_valid,
    output vec_data,
    input  vec_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  vec_valid,
    input  vec_data,
    output vec_ready,
    output out_valid,
    output out_data,
    output out_last
  );
endinterface

// File: rtl/shiftreg_chain_ctrl.sv
// Sequencer for a chain of DEPTH int8 shift-register stages.
// It parallel-loads an accepted vector into the chain, counts DEPTH shift
// cycles and tags the serial stream leaving stage 0 with valid/last.
// A new vector can be accepted on the last beat, so back-to-back vectors
// stream without a bubble.
// Optional macro SRCTRL_REPEAT_EN: adds cfg_repeat and rotates the chain
// (tail fed from head) so that one vector is streamed cfg_repeat+1 times.
module shiftreg_chain_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
`ifdef SRCTRL_REPEAT_EN
  input  logic [3:0]         cfg_repeat,
`endif
  shiftreg_chain_ctrl_if.slave bus,
  output logic               sr_load,
  output logic [DEPTH*8-1:0] sr_pload,
  output logic [7:0]         sr_fill,
  input  logic [7:0]         sr_head,
  output logic               busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          at_last;
  logic          rep_pending;
  logic          ready;
  logic          handshake;

`ifdef SRCTRL_REPEAT_EN
  logic [3:0] rep_reg, rep_next;

  assign rep_pending = (rep_reg != 4'd0);
  // Rotate: the element leaving the head re-enters at the tail.
  assign sr_fill     = sr_head;

  // Remaining extra passes for the vector in flight.
  always_ff @(posedge clk) begin
    if (!reset) rep_reg <= 4'd0;
    else        rep_reg <= rep_next;
  end
`else
  assign rep_pending = 1'b0;
  assign sr_fill     = 8'h00;
`endif

  // Vector slices go straight to the stage parallel inputs.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pload
      assign sr_pload[gi*8 +: 8] = bus.vec_data[gi*8 +: 8];
    end
  endgenerate

  assign bus.out_data  = sr_head;
  assign bus.out_valid = (state_reg == SHIFT);
  assign bus.out_last  = at_last;
  assign bus.vec_ready = ready;
  assign sr_load       = handshake;
  assign busy          = (state_reg != IDLE);

  // State and shift-counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Accept point, next state and counter advance.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
`ifdef SRCTRL_REPEAT_EN
    rep_next   = rep_reg;
`endif
    at_last    = (state_reg == SHIFT) && (cnt_reg == LAST);
    ready      = (state_reg == IDLE) || (at_last && !rep_pending);
    handshake  = bus.vec_valid && ready;

    case (state_reg)
      IDLE: begin
        if (handshake) begin
          state_next = SHIFT;
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        if (!at_last) begin
          cnt_next = cnt_reg + CW'(1);
        end else if (rep_pending) begin
          // Chain has rotated back to element 0: start another pass.
          cnt_next = '0;
`ifdef SRCTRL_REPEAT_EN
          rep_next = rep_reg - 4'd1;
`endif
        end else if (handshake) begin
          cnt_next = '0;
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

`ifdef SRCTRL_REPEAT_EN
    if (handshake) rep_next = cfg_repeat;
`endif
  end

endmodule
